key_direction_decoder: RTL and testbench
========================================

# key_direction_decoder

Translates PS/2 scan-code set 2 bytes from the keyboard byte receiver into the two `directions` commands consumed by the player-movement controller. Player 1 is driven by W/A/S/D, player 2 by the E0-prefixed arrow keys. Each output follows held-key semantics: the most recently pressed held key wins, and release falls back to any other held key or to `WAIT`. The block sits between the PS/2 byte receiver and the movement controller, in the `clk` domain.

## Interface
Parameters:
- None. Scan codes are package constants.

Ports:
- `clk`  in  1  system clock; the design's single clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received scan-code byte; valid only while `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe, one per received byte; may arrive on consecutive cycles.
- `direction_1`  out  `directions`  player 1 command: `WAIT`/`UP`/`DOWN`/`LEFT`/`RIGHT`.
- `direction_2`  out  `directions`  player 2 command, same encoding.
- `dir_change`  out  1  one-cycle pulse whenever either direction output changes value.

## Operation
- Key map, player 1 (non-extended):
  - W=0x1D → UP
  - S=0x1B → DOWN
  - A=0x1C → LEFT
  - D=0x23 → RIGHT
- Key map, player 2 (extended, E0 prefix):
  - 0x75 → UP
  - 0x72 → DOWN
  - 0x6B → LEFT
  - 0x74 → RIGHT
- Prefix FSM, advancing only on `rx_valid`:
  - `IDLE`: 0xE0 → `EXT`; 0xF0 → `BRK`; any other byte is a make code → decode, stay `IDLE`.
  - `EXT`: 0xF0 → `EXT_BRK`; any other byte is an extended make → decode → `IDLE`.
  - `BRK`: any byte is a non-extended break → decode → `IDLE`.
  - `EXT_BRK`: any byte is an extended break → decode → `IDLE`.
- Codes outside the key map (including the 0xE1 Pause sequence and E0 12 fake-shift) are ignored. The FSM still returns to `IDLE` as listed.
- Per-player resolver state:
  - 4-bit `held` mask (U, D, L, R) plus current direction `cur`.
- Make of key k:
  - Set `held[k]`; `cur` ← k.
  - A typematic repeat of an already-held k also sets `cur` ← k; no other effect.
- Break of key k:
  - Clear `held[k]`.
  - If k == `cur`, `cur` ← highest-priority key remaining in the updated mask, priority UP > DOWN > LEFT > RIGHT, or `WAIT` if the mask is empty.
  - If k ≠ `cur`, `cur` is unchanged.
  - A break of a key that is not held is a no-op.
- Player 1 and player 2 are independent: an event for one never alters the other.
- `dir_change` = OR over both players of (new `cur` ≠ old `cur`).

## Timing
- Reset values: `direction_1` = `direction_2` = `WAIT`, `dir_change` = 0, both `held` = 0, FSM in `IDLE`.
- Latency: directions and `dir_change` are registered and update on the clock edge following the `rx_valid` cycle carrying the final byte of a sequence.
  - A prefix byte alone causes no output change.
- Back-to-back `rx_valid` on consecutive cycles must be accepted with no byte loss.
- `rst` has priority over `rx_valid` in the same cycle.
  - Reset mid-sequence (after E0 or F0) discards the prefix.
  - The next byte is then interpreted from `IDLE`.
- Outputs hold their value indefinitely between events; there is no timeout.

## Structure
- Add to `game_pkg`:
  - scan-code constants: `KEY_W`, `KEY_A`, `KEY_S`, `KEY_D`, `KEY_UP`, `KEY_DOWN`, `KEY_LEFT`, `KEY_RIGHT`, `SC_EXT` = 0xE0, `SC_BRK` = 0xF0;
  - an FSM state typedef `ps2_state` (`IDLE`, `EXT`, `BRK`, `EXT_BRK`).
- `directions` is reused from `game_pkg` unchanged.
- Sub-module `dir_resolver`, instantiated twice (one per player):
  - inputs: `clk`, `rst`, `key_ev`, `key_make`, `key_id[1:0]`;
  - outputs: `dir`, `changed`.
  - It holds the `held` mask and the fallback priority logic.
- The top level contains the prefix FSM and the routing of decoded events to the correct resolver.

## Test plan
- Reset → both directions `WAIT`, `dir_change` 0; then bytes 1D → `direction_1`=UP one cycle after the strobe, `dir_change` pulses once, `direction_2` stays `WAIT`.
- E0 74 → `direction_2`=RIGHT; then E0 F0 74 → `direction_2`=`WAIT`; no cycle shows a change on `direction_1`.
- Held fallback: 1D, 1C, 23 → `direction_1`=RIGHT; F0 23 → UP (UP beats LEFT); F0 1D → LEFT; F0 1C → `WAIT`.
- Non-current release: 1B, 1C → LEFT; F0 1B → LEFT unchanged with no `dir_change`; repeated make 1C 1C 1C → no `dir_change`.
- Unknown and prefix handling: 2A, E0 2A, E1 14 77 E1 F0 14 F0 77 → no output change, FSM back in `IDLE`; a following 23 → `direction_1`=RIGHT.
- Back-to-back and reset: E0 F0 74 sent on three consecutive cycles is decoded correctly; `rst` asserted after E0, then 75 → treated as non-extended 0x75 (unmapped), so `direction_2` stays `WAIT`.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types: movement commands, PS/2 scan-code constants and key lookup helpers.
// Pure declarations and functions; no state.
package game_pkg;

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } directions;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;

  // Key ids double as bit positions in the held mask.
  localparam logic [1:0] ID_UP    = 2'd0;
  localparam logic [1:0] ID_DOWN  = 2'd1;
  localparam logic [1:0] ID_LEFT  = 2'd2;
  localparam logic [1:0] ID_RIGHT = 2'd3;

  typedef struct packed {
    logic       hit;
    logic [1:0] id;
  } key_hit_t;

  function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r.hit = 1'b1;
    r.id  = ID_UP;
    if (!ext) begin
      case (code)
        KEY_W:   r.id = ID_UP;
        KEY_S:   r.id = ID_DOWN;
        KEY_A:   r.id = ID_LEFT;
        KEY_D:   r.id = ID_RIGHT;
        default: r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        KEY_UP:    r.id = ID_UP;
        KEY_DOWN:  r.id = ID_DOWN;
        KEY_LEFT:  r.id = ID_LEFT;
        KEY_RIGHT: r.id = ID_RIGHT;
        default:   r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic directions id_to_dir(input logic [1:0] id);
    directions d;
    case (id)
      ID_UP:    d = UP;
      ID_DOWN:  d = DOWN;
      ID_LEFT:  d = LEFT;
      default:  d = RIGHT;
    endcase
    return d;
  endfunction

  function automatic directions prio_dir(input logic [3:0] held);
    directions d;
    if (held[ID_UP])         d = UP;
    else if (held[ID_DOWN])  d = DOWN;
    else if (held[ID_LEFT])  d = LEFT;
    else if (held[ID_RIGHT]) d = RIGHT;
    else                     d = WAIT;
    return d;
  endfunction

endpackage

// File: rtl/key_direction_decoder_if.sv
// Byte-receiver to movement-controller bundle: scan-code strobe in, two direction commands out.
// No backpressure: the decoder consumes every rx_valid byte.
interface key_direction_decoder_if;
  import game_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  directions  direction_1;
  directions  direction_2;
  logic       dir_change;

  modport master (
    output rx_data,
    output rx_valid,
    input  direction_1,
    input  direction_2,
    input  dir_change
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output direction_1,
    output direction_2,
    output dir_change
  );

endinterface

// File: rtl/key_direction_decoder_dir_resolver.sv
// Per-player held-key resolver: latest make wins, break falls back by UP>DOWN>LEFT>RIGHT priority.
// One-cycle registered latency; accepts an event every cycle, no backpressure.
module dir_resolver
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ev,
  input  logic       key_make,
  input  logic [1:0] key_id,
  output directions  dir,
  output logic       changed
);

  logic [3:0] held;
  logic [3:0] held_nxt;
  directions  cur_nxt;

  // cur always names a held key or WAIT, so a break of a non-held key can be dropped outright.
  always_comb begin
    held_nxt = held;
    cur_nxt  = dir;
    if (key_ev) begin
      if (key_make) begin
        held_nxt[key_id] = 1'b1;
        cur_nxt          = id_to_dir(key_id);
      end else if (held[key_id]) begin
        held_nxt[key_id] = 1'b0;
        if (dir == id_to_dir(key_id)) begin
          cur_nxt = prio_dir(held_nxt);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held    <= 4'b0000;
      dir     <= WAIT;
      changed <= 1'b0;
    end else begin
      held    <= held_nxt;
      dir     <= cur_nxt;
      changed <= (cur_nxt != dir);
    end
  end

endmodule

// File: rtl/key_direction_decoder.sv
// PS/2 set-2 prefix decoder routing W/A/S/D to player 1 and E0 arrows to player 2.
// Outputs update one cycle after the final byte of a sequence; every byte is accepted, no backpressure.
module key_direction_decoder
  import game_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  key_direction_decoder_if.slave bus
);

  ps2_state   state;
  ps2_state   state_nxt;
  logic       ev_vld;
  logic       ev_make;
  logic       ev_ext;
  key_hit_t   hit;
  logic       p1_ev;
  logic       p2_ev;
  directions  dir_1;
  directions  dir_2;
  logic       chg_1;
  logic       chg_2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.rx_valid) begin
      case (state)
        IDLE: begin
          if (bus.rx_data == SC_EXT)      state_nxt = EXT;
          else if (bus.rx_data == SC_BRK) state_nxt = BRK;
          else                            state_nxt = IDLE;
        end
        EXT: begin
          if (bus.rx_data == SC_BRK) state_nxt = EXT_BRK;
          else                       state_nxt = IDLE;
        end
        BRK:     state_nxt = IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A byte is a key event when it terminates a sequence rather than extending the prefix.
  always_comb begin
    ev_vld  = 1'b0;
    ev_make = 1'b1;
    ev_ext  = 1'b0;
    if (bus.rx_valid) begin
      case (state)
        IDLE: begin
          ev_vld = (bus.rx_data != SC_EXT) && (bus.rx_data != SC_BRK);
        end
        EXT: begin
          ev_vld = (bus.rx_data != SC_BRK);
          ev_ext = 1'b1;
        end
        BRK: begin
          ev_vld  = 1'b1;
          ev_make = 1'b0;
        end
        EXT_BRK: begin
          ev_vld  = 1'b1;
          ev_make = 1'b0;
          ev_ext  = 1'b1;
        end
        default: ev_vld = 1'b0;
      endcase
    end
  end

  assign hit   = key_lookup(bus.rx_data, ev_ext);
  assign p1_ev = ev_vld && hit.hit && !ev_ext;
  assign p2_ev = ev_vld && hit.hit && ev_ext;

  dir_resolver u_res_1 (
    .clk      (clk),
    .rst      (rst),
    .key_ev   (p1_ev),
    .key_make (ev_make),
    .key_id   (hit.id),
    .dir      (dir_1),
    .changed  (chg_1)
  );

  dir_resolver u_res_2 (
    .clk      (clk),
    .rst      (rst),
    .key_ev   (p2_ev),
    .key_make (ev_make),
    .key_id   (hit.id),
    .dir      (dir_2),
    .changed  (chg_2)
  );

  assign bus.direction_1 = dir_1;
  assign bus.direction_2 = dir_2;
  assign bus.dir_change  = chg_1 | chg_2;

endmodule

// File: tb/tb_key_direction_decoder.sv
// Scoreboard bench: each driven byte queues its expected outputs; a monitor checks them one cycle later.
module tb_key_direction_decoder;
  import game_pkg::*;

  typedef struct packed {
    directions d1;
    directions d2;
    logic      chg;
  } exp_t;

  logic clk;
  logic rst;
  key_direction_decoder_if bus ();

  key_direction_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   vec_n  = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, req);
  endtask

  task automatic send(input logic [7:0] b, input directions d1, input directions d2, input logic chg);
    exp_t e;
    e.d1  = d1;
    e.d2  = d2;
    e.chg = chg;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".dir1"}, int'(bus.direction_1), int'(WAIT));
    chk({nm, ".dir2"}, int'(bus.direction_2), int'(WAIT));
    chk({nm, ".chg"},  int'(bus.dir_change),  0);
  endtask

  // Monitor: the DUT presents a response on the cycle after every accepted byte.
  initial begin
    forever begin
      logic took;
      exp_t e;
      @(posedge clk);
      took = bus.rx_valid && !rst;
      @(negedge clk);
      if (took) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL v%0d.queue: got response with no expectation, want queued entry", vec_n);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d.dir1", vec_n), int'(bus.direction_1), int'(e.d1));
          chk($sformatf("v%0d.dir2", vec_n), int'(bus.direction_2), int'(e.d2));
          chk($sformatf("v%0d.chg",  vec_n), int'(bus.dir_change),  int'(e.chg));
        end
        vec_n++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset("reset");

    // First make on player 1
    send(8'h1D, UP, WAIT, 1'b1);
    idle(2);

    // Player 2 extended make/break
    send(8'hE0, UP, WAIT,  1'b0);
    send(8'h74, UP, RIGHT, 1'b1);
    idle(1);
    send(8'hE0, UP, RIGHT, 1'b0);
    send(8'hF0, UP, RIGHT, 1'b0);
    send(8'h74, UP, WAIT,  1'b1);
    idle(1);

    // Held fallback
    send(8'h1D, UP,    WAIT, 1'b0);
    send(8'h1C, LEFT,  WAIT, 1'b1);
    send(8'h23, RIGHT, WAIT, 1'b1);
    send(8'hF0, RIGHT, WAIT, 1'b0);
    send(8'h23, UP,    WAIT, 1'b1);
    send(8'hF0, UP,    WAIT, 1'b0);
    send(8'h1D, LEFT,  WAIT, 1'b1);
    send(8'hF0, LEFT,  WAIT, 1'b0);
    send(8'h1C, WAIT,  WAIT, 1'b1);
    idle(1);

    // Non-current release and typematic repeat
    send(8'h1B, DOWN, WAIT, 1'b1);
    send(8'h1C, LEFT, WAIT, 1'b1);
    send(8'hF0, LEFT, WAIT, 1'b0);
    send(8'h1B, LEFT, WAIT, 1'b0);
    send(8'h1C, LEFT, WAIT, 1'b0);
    send(8'h1C, LEFT, WAIT, 1'b0);
    send(8'h1C, LEFT, WAIT, 1'b0);
    idle(1);

    // Unknown codes, fake shift and Pause
    send(8'h2A, LEFT, WAIT, 1'b0);
    send(8'hE0, LEFT, WAIT, 1'b0);
    send(8'h2A, LEFT, WAIT, 1'b0);
    send(8'hE0, LEFT, WAIT, 1'b0);
    send(8'h12, LEFT, WAIT, 1'b0);
    send(8'hE1, LEFT, WAIT, 1'b0);
    send(8'h14, LEFT, WAIT, 1'b0);
    send(8'h77, LEFT, WAIT, 1'b0);
    send(8'hE1, LEFT, WAIT, 1'b0);
    send(8'hF0, LEFT, WAIT, 1'b0);
    send(8'h14, LEFT, WAIT, 1'b0);
    send(8'hF0, LEFT, WAIT, 1'b0);
    send(8'h77, LEFT, WAIT, 1'b0);
    send(8'h23, RIGHT, WAIT, 1'b1);

    // Back-to-back bytes across both players
    send(8'hE0, RIGHT, WAIT,  1'b0);
    send(8'h74, RIGHT, RIGHT, 1'b1);
    send(8'hE0, RIGHT, RIGHT, 1'b0);
    send(8'hF0, RIGHT, RIGHT, 1'b0);
    send(8'h74, RIGHT, WAIT,  1'b1);
    send(8'h1D, UP,    WAIT,  1'b1);
    send(8'hE0, UP,    WAIT,  1'b0);
    send(8'h72, UP,    DOWN,  1'b1);

    // Reset after E0 wins over a same-cycle byte and drops the prefix
    send(8'hE0, UP, DOWN, 1'b0);
    rst          = 1'b1;
    bus.rx_data  = 8'h74;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst          = 1'b0;
    chk_reset("mid_ext_reset");
    send(8'h75, WAIT, WAIT, 1'b0);
    idle(1);

    // Reset after F0 turns the next byte into a make, with held mask cleared
    send(8'h1D, UP, WAIT, 1'b1);
    send(8'hF0, UP, WAIT, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk_reset("mid_brk_reset");
    send(8'h1D, UP, WAIT, 1'b1);
    send(8'hF0, UP, WAIT, 1'b0);
    send(8'h1C, UP, WAIT, 1'b0);
    idle(3);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
